// File: rtl/fifo_ctrl_pkg.sv
// Shared defaults, reset values and occupancy helper for the FIFO pointer/flag controller.
package fifo_ctrl_pkg;

    localparam int unsigned DEF_AW        = 4;
    localparam int unsigned DEF_AFULL_TH  = 12;
    localparam int unsigned DEF_AEMPTY_TH = 4;

    localparam logic [31:0] PTR_RST_VAL = 32'd0;
    localparam logic        OVF_RST_VAL = 1'b0;
    localparam logic        UDF_RST_VAL = 1'b0;

    // Pointers are passed zero-extended; the mask keeps the AW+1-bit modulo wrap.
    function automatic logic [31:0] ptr_occupancy(input logic [31:0] wptr,
                                                  input logic [31:0] rptr,
                                                  input int unsigned aw);
        logic [31:0] mask;
        mask = (32'd1 << (aw + 32'd1)) - 32'd1;
        return (wptr - rptr) & mask;
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping AW+1-bit pointer register with increment enable and synchronous clear.
module fifo_ptr
    import fifo_ctrl_pkg::*;
#(
    parameter int unsigned W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         srst,
    input  logic         inc,
    output logic [W-1:0] ptr
);

    logic [W-1:0] ptr_r;

    // Pointer state: async reset, flush clear, then wrapping increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= PTR_RST_VAL[W-1:0];
        end else if (srst) begin
            ptr_r <= PTR_RST_VAL[W-1:0];
        end else if (inc) begin
            ptr_r <= ptr_r + {{(W-1){1'b0}}, 1'b1};
        end
    end

    assign ptr = ptr_r;

endmodule

// File: rtl/fifo_ctrl.sv
// FIFO pointer and flag controller. Optional sticky overflow/underflow flags
// are built when FIFO_ERR_FLAGS_EN is defined.
module fifo_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int unsigned AW        = DEF_AW,
    parameter int unsigned AFULL_TH  = DEF_AFULL_TH,
    parameter int unsigned AEMPTY_TH = DEF_AEMPTY_TH
) (
    input  logic          fc_clk,
    input  logic          fc_clear_n,
    input  logic          fc_wr_req,
    input  logic          fc_rd_req,
    input  logic          fc_flush,
    output logic          fc_wr_en,
    output logic [AW-1:0] fc_wr_addr,
    output logic          fc_rd_en,
    output logic [AW-1:0] fc_rd_addr,
    output logic          fc_full,
    output logic          fc_empty,
    output logic          fc_afull,
    output logic          fc_aempty,
`ifdef FIFO_ERR_FLAGS_EN
    output logic          fc_ovf,
    output logic          fc_udf,
`endif
    output logic [AW:0]   fc_count
);

    localparam logic [31:0] AFULL_TH_W  = AFULL_TH;
    localparam logic [31:0] AEMPTY_TH_W = AEMPTY_TH;

    logic [AW:0] wptr_s;
    logic [AW:0] rptr_s;
    logic [31:0] occ_unused_s;
    logic [AW:0] count_s;
    logic        full_s;
    logic        empty_s;
    logic        wr_en_s;
    logic        rd_en_s;

    fifo_ptr #(.W(AW + 1)) u_wptr (
        .clk   (fc_clk),
        .rst_n (fc_clear_n),
        .srst  (fc_flush),
        .inc   (wr_en_s),
        .ptr   (wptr_s)
    );

    fifo_ptr #(.W(AW + 1)) u_rptr (
        .clk   (fc_clk),
        .rst_n (fc_clear_n),
        .srst  (fc_flush),
        .inc   (rd_en_s),
        .ptr   (rptr_s)
    );

    assign occ_unused_s = ptr_occupancy({{(31 - AW){1'b0}}, wptr_s},
                                        {{(31 - AW){1'b0}}, rptr_s}, AW);
    assign count_s      = occ_unused_s[AW:0];
    assign empty_s      = (wptr_s == rptr_s);
    assign full_s       = (wptr_s[AW-1:0] == rptr_s[AW-1:0]) && (wptr_s[AW] != rptr_s[AW]);

    // Accept gating: flush overrides both requesters, full/empty block the respective side.
    always_comb begin
        wr_en_s = 1'b0;
        rd_en_s = 1'b0;
        if (fc_flush) begin
            wr_en_s = 1'b0;
            rd_en_s = 1'b0;
        end else begin
            wr_en_s = fc_wr_req & ~full_s;
            rd_en_s = fc_rd_req & ~empty_s;
        end
    end

    assign fc_wr_en   = wr_en_s;
    assign fc_rd_en   = rd_en_s;
    assign fc_wr_addr = wptr_s[AW-1:0];
    assign fc_rd_addr = rptr_s[AW-1:0];
    assign fc_full    = full_s;
    assign fc_empty   = empty_s;
    assign fc_count   = count_s;
    assign fc_afull   = (count_s >= AFULL_TH_W[AW:0]);
    assign fc_aempty  = (count_s <= AEMPTY_TH_W[AW:0]);

`ifdef FIFO_ERR_FLAGS_EN
    logic ovf_r;
    logic udf_r;

    // Sticky error flags for dropped requests; flush clears them with the pointers.
    always_ff @(posedge fc_clk or negedge fc_clear_n) begin
        if (!fc_clear_n) begin
            ovf_r <= OVF_RST_VAL;
            udf_r <= UDF_RST_VAL;
        end else if (fc_flush) begin
            ovf_r <= OVF_RST_VAL;
            udf_r <= UDF_RST_VAL;
        end else begin
            ovf_r <= ovf_r | (fc_wr_req & full_s);
            udf_r <= udf_r | (fc_rd_req & empty_s);
        end
    end

    assign fc_ovf = ovf_r;
    assign fc_udf = udf_r;
`endif

endmodule

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
Pointer and flag controller for the team's synchronous FIFO. Owns the write and read pointers, which are two instances of a wrapping enable counter. Drives the storage array's write strobe and address, and its read strobe and address. Gates requesters against full and empty, and publishes occupancy and almost-full/almost-empty status. Sits between the producer/consumer request lines and the dual-port register-file storage.

Parameters:
AW, 4, address width; FIFO depth = 2**AW entries
AFULL_TH, 12, occupancy at or above which fc_afull asserts (0..2**AW)
AEMPTY_TH, 4, occupancy at or below which fc_aempty asserts (0..2**AW)

Ports:
fc_clk  input  1  clock; all state updates on rising edge
fc_clear_n  input  1  asynchronous active-low reset
fc_wr_req  input  1  producer requests a write this cycle
fc_rd_req  input  1  consumer requests a read this cycle
fc_flush  input  1  synchronous flush; empties the FIFO
fc_wr_en  output  1  storage write strobe (accepted write)
fc_wr_addr  output  AW  storage write address
fc_rd_en  output  1  storage read strobe (accepted read)
fc_rd_addr  output  AW  storage read address
fc_full  output  1  FIFO holds 2**AW entries
fc_empty  output  1  FIFO holds 0 entries
fc_afull  output  1  occupancy >= AFULL_TH
fc_aempty  output  1  occupancy <= AEMPTY_TH
fc_count  output  AW+1  current occupancy, 0..2**AW

Behaviour:
- One clock, fc_clk. fc_clear_n is asynchronous, active-low.
- While fc_clear_n = 0:
  - Internal state: wptr = 0, rptr = 0.
  - Outputs: fc_count = 0, fc_empty = 1, fc_full = 0, fc_aempty = 1, fc_afull = 0, fc_wr_en = 0, fc_rd_en = 0, fc_wr_addr = 0, fc_rd_addr = 0.
- Pointers wptr and rptr are AW+1 bits, and each wraps modulo 2**(AW+1). The MSB is the lap bit.
- Addresses: fc_wr_addr = wptr[AW-1:0], fc_rd_addr = rptr[AW-1:0].
- Flags are combinational from the registered pointers, so there is zero added latency:
  - fc_count = (wptr - rptr) mod 2**(AW+1)
  - fc_empty = (wptr == rptr)
  - fc_full = (addresses equal) and (lap bits differ)
- Accept rules, combinational in the same cycle:
  - fc_wr_en = fc_wr_req & ~fc_full & ~fc_flush
  - fc_rd_en = fc_rd_req & ~fc_empty & ~fc_flush
- On a rising edge:
  - wptr increments if fc_wr_en; rptr increments if fc_rd_en.
  - Occupancy updates next cycle: +1, -1, or unchanged when both are accepted.
- Full and both requests: only the read is accepted. Occupancy goes to 2**AW-1 next cycle and fc_full drops.
- Empty and both requests: only the write is accepted, with no bypass. The data is readable the cycle after.
- Requests while full (write) or empty (read) are dropped silently. No state change.
- fc_flush = 1:
  - Both strobes are forced to 0.
  - On the next edge both pointers go to 0, so the FIFO empties.
  - Flush overrides any concurrent requests.
- Reset mid-operation: state clears immediately (asynchronous). Stored data is abandoned. Operation resumes on the first edge after release.
- Almost flags use unsigned compares against fc_count. If AFULL_TH = 0, fc_afull is constantly 1.

Optional Feature:
- Macro: FIFO_ERR_FLAGS_EN.
- When defined, two outputs are added:
  - fc_ovf: sticky, set on any edge where fc_wr_req & fc_full & ~fc_flush.
  - fc_udf: sticky, set on any edge where fc_rd_req & fc_empty & ~fc_flush.
  - Both clear on reset or flush.
- When undefined, these ports and registers do not exist. Dropped requests remain silent.

Decomposition:
- Package fifo_ctrl_pkg holds:
  - Default AW, AFULL_TH and AEMPTY_TH constants.
  - A function computing occupancy from two AW+1 pointers.
  - Reset-value constants for pointers and flags.
- One sub-module, fifo_ptr: an AW+1-bit register with increment enable, synchronous clear (driven by flush) and asynchronous active-low reset. Instantiated twice, once for wptr and once for rptr.

Test Plan:
- Reset and release, then idle:
  - Required: fc_empty=1, fc_full=0, fc_count=0, fc_aempty=1, both strobes 0.
- 16 consecutive writes, AW=4:
  - fc_wr_addr steps 0..15.
  - fc_count goes to 16; fc_full=1; fc_afull asserts once count >= 12.
  - A 17th write request gives fc_wr_en=0, and count stays 16.
- Full, then simultaneous read and write:
  - Only the read is accepted; next cycle fc_count=15 and fc_full=0.
- Empty, then simultaneous read and write:
  - Only the write is accepted; next cycle fc_count=1 and fc_empty=0.
- Write 40, read 40 interleaved:
  - Addresses wrap 15 -> 0 and lap bits toggle.
  - Ends with fc_count=0, fc_empty=1, and no false fc_full at equal addresses.
- Fill to 9, then assert fc_flush together with fc_wr_req:
  - Required: fc_wr_en=0 that cycle; next cycle fc_count=0 and both addresses 0.
  - With FIFO_ERR_FLAGS_EN: after an overflow attempt fc_ovf=1 until flush, and a read on empty sets fc_udf=1.
